axi_slave_write_ctrl: RTL
=========================

AXI_SLAVE_WRITE_CTRL -- requirements
Module: axi_slave_write_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 Port list, one per line (name, direction, width, meaning), SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_aresetn  in  1  AXI reset, active-low, sampled on clk
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  12/32/8/3/2/1  AW channel
- s_axi_awready  out  1  AW ready
- s_axi_wid/wdata/wstrb/wlast/wvalid  in  12/32/4/1/1  W channel
- s_axi_wready  out  1  W ready
- s_axi_bid/bresp/bvalid  out  12/2/1  B channel
- s_axi_bready  in  1  B ready
- write_ready  in  1  backend can take a beat this cycle
- wr_en/wr_addr/wr_data/wr_strb  out  1/32/32/4  backend beat, valid for one cycle
- tx_wactive/tx_bwait  out  1/1  in DATA / in RESP state

Function
REQ-003 The FSM SHALL have states IDLE, DATA and RESP.
REQ-004 In IDLE, awready SHALL be 1. An AW handshake SHALL latch awid, awaddr, awlen, awsize and awburst, clear the beat counter and error flag, and enter DATA on the next cycle.
REQ-005 In DATA, wready SHALL equal write_ready. Outside DATA, wready SHALL be 0.
REQ-006 A W handshake SHALL drive wr_en=1 combinationally in the same cycle, with wr_addr set to the current beat address and wdata/wstrb passed through. wr_en SHALL be 0 otherwise.
REQ-007 A burst SHALL be exactly awlen+1 beats. The counter is 8 bits and compares against the latched awlen.
REQ-008 Address update per beat, mod 2^32:
- FIXED: address unchanged.
- INCR: address += 1<<awsize.
- WRAP: with bound = (awlen+1)<<awsize, address = (address & ~(bound-1)) | ((address + (1<<awsize)) & (bound-1)).
REQ-009 A burst value of 2'b11 SHALL be handled as INCR and SHALL set the error flag.
REQ-010 If wlast is 1 on a non-final beat, or 0 on the final beat, the error flag SHALL be set. The beat count alone decides where the burst ends.
REQ-011 The final-beat handshake in cycle t SHALL give bvalid=1 at t+1 (state RESP), with bid = latched awid and bresp = 2'b10 if the error flag is set, else 2'b00.
REQ-012 bvalid, bid and bresp SHALL stay stable until bready. A B handshake in cycle t SHALL give IDLE with awready=1 at t+1.
REQ-013 AW, W and B handshakes SHALL never complete in the same cycle, because the states are mutually exclusive.

Reset
REQ-014 Either rst=1 or s_axi_aresetn=0, sampled at a clock edge, SHALL put the block in IDLE with:
- awready=1, wready=0, bvalid=0, bid=0, bresp=0
- tx_wactive=0, tx_bwait=0
- latched awlen/awsize/awaddr/awburst = 0
REQ-015 A reset mid-burst or mid-response SHALL abandon the transaction, give wr_en=0 in the reset cycle, and issue no B response.

Configuration
REQ-016 With AXI_WID_CHECK_EN defined, a W beat whose wid differs from the latched awid SHALL set the error flag. The beat is still written.
REQ-017 Without AXI_WID_CHECK_EN, wid SHALL be ignored.

Structure
REQ-018 Package axi_slave_pkg SHALL hold:
- burst type enum (FIXED=0, INCR=1, WRAP=2)
- response codes OKAY=2'b00, SLVERR=2'b10
- FSM state enum
- ID, address and data width parameters
REQ-019 Address update SHALL live in a combinational sub-module axi_burst_addr_gen (inputs: addr, size, len, burst; output: next_addr).

Verification
REQ-020 INCR burst: AW (id=0x005, addr=0x1000, len=3, size=2, burst=INCR), then 4 beats with wlast on the 4th, write_ready=1 -> wr_addr 0x1000, 0x1004, 0x1008, 0x100C; bvalid at the cycle after the last beat with bid=0x005, bresp=0.
REQ-021 WRAP burst: addr=0x1008, len=3, size=2 -> wr_addr 0x1008, 0x100C, 0x1000, 0x1004.
REQ-022 wlast error: single-beat AW (len=0) with wlast=0 -> one wr_en pulse, then bresp=2'b10.
REQ-023 Backpressure: write_ready low for 3 cycles mid-burst -> wready=0 and wr_en=0 during the stall; addresses continue correctly afterwards. bready held low for 5 cycles -> B outputs stable and awready=0.
REQ-024 Reset mid-burst: rst=1 after beat 2 of 4 -> next cycle awready=1, bvalid=0, tx_wactive=0; a following burst completes with bresp=0.
REQ-025 With AXI_WID_CHECK_EN: awid=0x001, wid=0x002 -> bresp=2'b10. Without the macro, the same stimulus -> bresp=2'b00.

Source files
------------

// File: rtl/axi_slave_pkg.sv
// Shared types and widths for the AXI slave write controller.
package axi_slave_pkg;

   localparam int ID_W   = 12;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   // Encoded AXI burst types; 2'b11 is reserved and treated as INCR.
   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts (mod 2^32).
module axi_burst_addr_gen
   import axi_slave_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] incr_addr;

   assign step      = ADDR_W'(1) << size;
   // Wrap boundary is (len+1) << size; the mask selects the in-window offset.
   assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
   assign incr_addr = addr + step;

   // Select the next address by burst type.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      next_addr = incr_addr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_slave_write_ctrl.sv
// AXI slave write controller: accepts one AW burst at a time, forwards each
// W beat to a simple backend port and returns a single B response.
// Optional build macro: AXI_WID_CHECK_EN flags W beats whose wid differs from awid.
module axi_slave_write_ctrl
   import axi_slave_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_axi_aresetn,
   input  logic [ID_W-1:0]   s_axi_awid,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [ID_W-1:0]   s_axi_wid,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0] s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [ID_W-1:0]   s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic              write_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [STRB_W-1:0] wr_strb,
   output logic              tx_wactive,
   output logic              tx_bwait
);

   state_t            state;
   logic [ID_W-1:0]   awid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        awlen_q;
   logic [2:0]        awsize_q;
   logic [1:0]        awburst_q;
   logic [7:0]        beat_cnt;
   logic              err_q;

   logic              sync_rst;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              last_beat;
   logic              wlast_err;
   logic              wid_err;
   logic              err_nxt;
   logic [ADDR_W-1:0] next_addr;

   // Either reset source abandons the transaction; gating wready keeps wr_en low in the reset cycle.
   assign sync_rst     = rst | ~s_axi_aresetn;
   assign s_axi_wready = (state == ST_DATA) & write_ready & ~sync_rst;

   assign aw_hs     = s_axi_awready & s_axi_awvalid;
   assign w_hs      = s_axi_wready & s_axi_wvalid;
   assign b_hs      = s_axi_bvalid & s_axi_bready;
   // The beat count alone ends the burst; wlast is only checked for consistency.
   assign last_beat = (beat_cnt == awlen_q);
   assign wlast_err = (s_axi_wlast != last_beat);

`ifdef AXI_WID_CHECK_EN
   assign wid_err = (s_axi_wid != awid_q);
`else
   logic unused_wid;
   assign unused_wid = ^s_axi_wid;
   assign wid_err    = 1'b0;
`endif

   assign err_nxt = err_q | wlast_err | wid_err;

   assign wr_en   = w_hs;
   assign wr_addr = addr_q;
   assign wr_data = s_axi_wdata;
   assign wr_strb = s_axi_wstrb;

   axi_burst_addr_gen u_addr_gen (
      .addr      (addr_q),
      .size      (awsize_q),
      .len       (awlen_q),
      .burst     (awburst_q),
      .next_addr (next_addr)
   );

   // Burst FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (sync_rst) begin
         state         <= ST_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_bvalid  <= 1'b0;
         s_axi_bid     <= '0;
         s_axi_bresp   <= RESP_OKAY;
         tx_wactive    <= 1'b0;
         tx_bwait      <= 1'b0;
         awid_q        <= '0;
         addr_q        <= '0;
         awlen_q       <= '0;
         awsize_q      <= '0;
         awburst_q     <= '0;
         beat_cnt      <= '0;
         err_q         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (aw_hs) begin
                  awid_q        <= s_axi_awid;
                  addr_q        <= s_axi_awaddr;
                  awlen_q       <= s_axi_awlen;
                  awsize_q      <= s_axi_awsize;
                  awburst_q     <= s_axi_awburst;
                  beat_cnt      <= '0;
                  err_q         <= (s_axi_awburst == 2'b11);
                  s_axi_awready <= 1'b0;
                  tx_wactive    <= 1'b1;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  addr_q   <= next_addr;
                  beat_cnt <= beat_cnt + 8'd1;
                  err_q    <= err_nxt;
                  if (last_beat) begin
                     s_axi_bvalid <= 1'b1;
                     s_axi_bid    <= awid_q;
                     s_axi_bresp  <= err_nxt ? RESP_SLVERR : RESP_OKAY;
                     tx_wactive   <= 1'b0;
                     tx_bwait     <= 1'b1;
                     state        <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (b_hs) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  tx_bwait      <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state         <= ST_IDLE;
               s_axi_awready <= 1'b1;
               s_axi_bvalid  <= 1'b0;
               tx_wactive    <= 1'b0;
               tx_bwait      <= 1'b0;
            end
         endcase
      end
   end

endmodule
